id_ex_forward_reg: RTL and testbench

//  ID/EX pipeline register, directly downstream of the hazard/forwarding unit.

---
 rtl/id_ex_forward_reg_if.sv | 46 ++++
 rtl/id_ex_forward_reg.sv | 113 +++++++++++
 tb/tb_id_ex_forward_reg.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_forward_reg_if.sv
// rtl/id_ex_forward_reg_if.sv - ID/EX forwarding register bus: ID-side operands and controls in, EX-side state out
interface id_ex_forward_reg_if #(
  parameter int DW    = 32,
  parameter int CW    = 12,
  parameter int CNT_W = 16
);
  logic [1:0]       ISA;
  logic [1:0]       ISB;
  logic [1:0]       ISD;
  logic             C_Unit_MUX;
  logic             HOLD;
  logic             FLUSH;
  logic             CNT_CLR;
  logic [DW-1:0]    RA_VAL;
  logic [DW-1:0]    RB_VAL;
  logic [DW-1:0]    RD_VAL;
  logic [DW-1:0]    EX_FWD;
  logic [DW-1:0]    MEM_FWD;
  logic [DW-1:0]    WB_FWD;
  logic [CW-1:0]    CTRL_ID;
  logic [3:0]       RW_ID;

  logic [DW-1:0]    OPA_EX;
  logic [DW-1:0]    OPB_EX;
  logic [DW-1:0]    STD_EX;
  logic [CW-1:0]    CTRL_EX;
  logic [3:0]       RW_EX;
  logic             enable_RF_EX;
  logic             enable_LD_EX;
  logic             VALID_EX;
  logic [CNT_W-1:0] BUBBLE_CNT;

  modport master (
    output ISA, ISB, ISD, C_Unit_MUX, HOLD, FLUSH, CNT_CLR,
    output RA_VAL, RB_VAL, RD_VAL, EX_FWD, MEM_FWD, WB_FWD, CTRL_ID, RW_ID,
    input  OPA_EX, OPB_EX, STD_EX, CTRL_EX, RW_EX,
    input  enable_RF_EX, enable_LD_EX, VALID_EX, BUBBLE_CNT
  );

  modport slave (
    input  ISA, ISB, ISD, C_Unit_MUX, HOLD, FLUSH, CNT_CLR,
    input  RA_VAL, RB_VAL, RD_VAL, EX_FWD, MEM_FWD, WB_FWD, CTRL_ID, RW_ID,
    output OPA_EX, OPB_EX, STD_EX, CTRL_EX, RW_EX,
    output enable_RF_EX, enable_LD_EX, VALID_EX, BUBBLE_CNT
  );
endinterface

// File: rtl/id_ex_forward_reg.sv
// rtl/id_ex_forward_reg.sv - ID/EX pipeline register with operand forwarding, bubbles, hold and deferred flush
module id_ex_forward_reg #(
  parameter int DW    = 32,
  parameter int CW    = 12,
  parameter int CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  id_ex_forward_reg_if.slave   bus
);

  logic [DW-1:0]    opa_mux;
  logic [DW-1:0]    opb_mux;
  logic [DW-1:0]    std_mux;

  logic [DW-1:0]    opa_q;
  logic [DW-1:0]    opb_q;
  logic [DW-1:0]    std_q;
  logic [CW-1:0]    ctrl_q;
  logic [3:0]       rw_q;
  logic             valid_q;
  logic             flush_pend;
  logic [CNT_W-1:0] cnt_q;

  logic             flush_now;
  logic             do_squash;
  logic             do_bubble;
  logic             do_load;
  logic             cnt_full;

  function automatic logic [DW-1:0] fwd_pick(
    input logic [1:0]    sel,
    input logic [DW-1:0] rf_val,
    input logic [DW-1:0] ex_val,
    input logic [DW-1:0] mem_val,
    input logic [DW-1:0] wb_val
  );
    logic [DW-1:0] res;
    case (sel)
      2'b00:   res = rf_val;
      2'b01:   res = ex_val;
      2'b10:   res = mem_val;
      default: res = wb_val;
    endcase
    return res;
  endfunction

  always_comb begin
    opa_mux = fwd_pick(bus.ISA, bus.RA_VAL, bus.EX_FWD, bus.MEM_FWD, bus.WB_FWD);
    opb_mux = fwd_pick(bus.ISB, bus.RB_VAL, bus.EX_FWD, bus.MEM_FWD, bus.WB_FWD);
    std_mux = fwd_pick(bus.ISD, bus.RD_VAL, bus.EX_FWD, bus.MEM_FWD, bus.WB_FWD);
  end

  // A flush seen during HOLD is parked in flush_pend and applied on the first free cycle.
  assign flush_now = bus.FLUSH | flush_pend;
  assign do_squash = !bus.HOLD && flush_now;
  assign do_bubble = !bus.HOLD && !flush_now && !bus.C_Unit_MUX;
  assign do_load   = !bus.HOLD && !flush_now &&  bus.C_Unit_MUX;
  assign cnt_full  = &cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      opa_q      <= '0;
      opb_q      <= '0;
      std_q      <= '0;
      ctrl_q     <= '0;
      rw_q       <= '0;
      valid_q    <= 1'b0;
      flush_pend <= 1'b0;
    end else if (bus.HOLD) begin
      if (bus.FLUSH) begin
        flush_pend <= 1'b1;
      end
    end else if (do_squash || do_bubble) begin
      opa_q      <= '0;
      opb_q      <= '0;
      std_q      <= '0;
      ctrl_q     <= '0;
      rw_q       <= '0;
      valid_q    <= 1'b0;
      flush_pend <= 1'b0;
    end else if (do_load) begin
      opa_q      <= opa_mux;
      opb_q      <= opb_mux;
      std_q      <= std_mux;
      ctrl_q     <= bus.CTRL_ID;
      rw_q       <= bus.RW_ID;
      valid_q    <= 1'b1;
    end
  end

  // Clear wins over counting, but a bubble in the clearing cycle is still the first count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (bus.CNT_CLR) begin
      cnt_q <= do_bubble ? CNT_W'(1) : '0;
    end else if (do_bubble && !cnt_full) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.OPA_EX       = opa_q;
  assign bus.OPB_EX       = opb_q;
  assign bus.STD_EX       = std_q;
  assign bus.CTRL_EX      = ctrl_q;
  assign bus.RW_EX        = rw_q;
  assign bus.enable_RF_EX = ctrl_q[0];
  assign bus.enable_LD_EX = ctrl_q[1];
  assign bus.VALID_EX     = valid_q;
  assign bus.BUBBLE_CNT   = cnt_q;

endmodule

// File: tb/tb_id_ex_forward_reg.sv
// tb/tb_id_ex_forward_reg.sv - directed and random bench for id_ex_forward_reg against a behavioural model
module tb_id_ex_forward_reg;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  id_ex_forward_reg_if #(.DW(32), .CW(12), .CNT_W(16)) bus ();
  id_ex_forward_reg_if #(.DW(32), .CW(12), .CNT_W(4))  bus4 ();

  id_ex_forward_reg #(.DW(32), .CW(12), .CNT_W(16)) u_dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  id_ex_forward_reg #(.DW(32), .CW(12), .CNT_W(4)) u_dut4 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus4.slave)
  );

  assign bus4.ISA        = bus.ISA;
  assign bus4.ISB        = bus.ISB;
  assign bus4.ISD        = bus.ISD;
  assign bus4.C_Unit_MUX = bus.C_Unit_MUX;
  assign bus4.HOLD       = bus.HOLD;
  assign bus4.FLUSH      = bus.FLUSH;
  assign bus4.CNT_CLR    = bus.CNT_CLR;
  assign bus4.RA_VAL     = bus.RA_VAL;
  assign bus4.RB_VAL     = bus.RB_VAL;
  assign bus4.RD_VAL     = bus.RD_VAL;
  assign bus4.EX_FWD     = bus.EX_FWD;
  assign bus4.MEM_FWD    = bus.MEM_FWD;
  assign bus4.WB_FWD     = bus.WB_FWD;
  assign bus4.CTRL_ID    = bus.CTRL_ID;
  assign bus4.RW_ID      = bus.RW_ID;

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  logic [31:0] e_opa, e_opb, e_std;
  logic [11:0] e_ctrl;
  logic [3:0]  e_rw;
  logic        e_valid;
  logic        e_pend;
  int          e_cnt, e_cnt4;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_opa = 0; e_opb = 0; e_std = 0; e_ctrl = 0; e_rw = 0;
    e_valid = 0; e_pend = 0; e_cnt = 0; e_cnt4 = 0;
  endtask

  task automatic model_edge();
    logic [31:0] v[4];
    bit bub;
    bub = 0;
    if (bus.HOLD) begin
      if (bus.FLUSH) e_pend = 1;
    end else if (bus.FLUSH || e_pend) begin
      e_opa = 0; e_opb = 0; e_std = 0; e_ctrl = 0; e_rw = 0; e_valid = 0;
      e_pend = 0;
    end else if (!bus.C_Unit_MUX) begin
      e_opa = 0; e_opb = 0; e_std = 0; e_ctrl = 0; e_rw = 0; e_valid = 0;
      bub = 1;
    end else begin
      v = '{bus.RA_VAL, bus.EX_FWD, bus.MEM_FWD, bus.WB_FWD};
      e_opa = v[bus.ISA];
      v[0] = bus.RB_VAL;
      e_opb = v[bus.ISB];
      v[0] = bus.RD_VAL;
      e_std = v[bus.ISD];
      e_ctrl = bus.CTRL_ID;
      e_rw = bus.RW_ID;
      e_valid = 1;
    end
    if (bus.CNT_CLR) begin
      e_cnt  = bub ? 1 : 0;
      e_cnt4 = bub ? 1 : 0;
    end else if (bub) begin
      if (e_cnt < 65535) e_cnt++;
      if (e_cnt4 < 15) e_cnt4++;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".opa"},   bus.OPA_EX, e_opa);
    check({tag, ".opb"},   bus.OPB_EX, e_opb);
    check({tag, ".std"},   bus.STD_EX, e_std);
    check({tag, ".ctrl"},  bus.CTRL_EX, e_ctrl);
    check({tag, ".rw"},    bus.RW_EX, e_rw);
    check({tag, ".en_rf"}, bus.enable_RF_EX, e_ctrl[0]);
    check({tag, ".en_ld"}, bus.enable_LD_EX, e_ctrl[1]);
    check({tag, ".valid"}, bus.VALID_EX, e_valid);
    check({tag, ".cnt"},   bus.BUBBLE_CNT, e_cnt);
    check({tag, ".cnt4"},  bus4.BUBBLE_CNT, e_cnt4);
    check({tag, ".valid4"}, bus4.VALID_EX, e_valid);
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic set_idle();
    bus.ISA = 2'b00; bus.ISB = 2'b00; bus.ISD = 2'b00;
    bus.C_Unit_MUX = 1'b1; bus.HOLD = 1'b0; bus.FLUSH = 1'b0; bus.CNT_CLR = 1'b0;
  endtask

  task automatic rand_data();
    bus.RA_VAL = $urandom; bus.RB_VAL = $urandom; bus.RD_VAL = $urandom;
    bus.EX_FWD = $urandom; bus.MEM_FWD = $urandom; bus.WB_FWD = $urandom;
    bus.CTRL_ID = 12'($urandom); bus.RW_ID = 4'($urandom);
  endtask

  initial begin
    set_idle();
    rand_data();
    model_reset();
    @(posedge CLK);
    #1;
    check_all("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // Forward select walk on operand A
    bus.RA_VAL = 32'd1; bus.EX_FWD = 32'd2; bus.MEM_FWD = 32'd3; bus.WB_FWD = 32'd4;
    for (int k = 0; k < 4; k++) begin
      bus.ISA = 2'(k);
      bus.ISB = 2'(3 - k);
      step("fwd");
      check("fwd.opa_const", bus.OPA_EX, 64'(k + 1));
    end

    // Load-use bubble
    set_idle();
    bus.CTRL_ID = 12'hFFF; bus.RW_ID = 4'd5; bus.C_Unit_MUX = 1'b0;
    step("bubble");
    check("bubble.ctrl_zero", bus.CTRL_EX, 0);
    check("bubble.cnt_one", bus.BUBBLE_CNT, 1);

    // Hold for three cycles with a flush in the middle
    set_idle();
    rand_data();
    bus.CTRL_ID[0] = 1'b1;
    step("hf.load");
    for (int k = 0; k < 3; k++) begin
      bus.HOLD = 1'b1;
      bus.FLUSH = (k == 1);
      rand_data();
      step("hf.hold");
      check("hf.frozen_valid", bus.VALID_EX, 1);
    end
    set_idle();
    rand_data();
    step("hf.squash");
    check("hf.squash_valid", bus.VALID_EX, 0);
    check("hf.cnt_same", bus.BUBBLE_CNT, 1);
    rand_data();
    step("hf.resume");
    check("hf.resume_valid", bus.VALID_EX, 1);

    // Repeated flush pulses during one hold collapse to a single squash
    for (int k = 0; k < 4; k++) begin
      bus.HOLD = 1'b1;
      bus.FLUSH = k[0];
      step("mf.hold");
    end
    set_idle();
    step("mf.squash");
    rand_data();
    step("mf.resume");
    check("mf.resume_valid", bus.VALID_EX, 1);

    // Counter saturation on the 4-bit build
    set_idle();
    bus.CNT_CLR = 1'b1;
    step("sat.clr");
    set_idle();
    bus.C_Unit_MUX = 1'b0;
    for (int k = 0; k < 20; k++) step("sat.bub");
    check("sat.cnt4_15", bus4.BUBBLE_CNT, 15);
    check("sat.cnt16_20", bus.BUBBLE_CNT, 20);
    bus.CNT_CLR = 1'b1;
    step("sat.clr_bub");
    check("sat.clr_bub4", bus4.BUBBLE_CNT, 1);

    // Store data from MEM forward
    set_idle();
    rand_data();
    bus.ISD = 2'b10; bus.MEM_FWD = 32'hDEADBEEF; bus.CTRL_ID[2] = 1'b1;
    step("store");
    check("store.std", bus.STD_EX, 32'hDEADBEEF);
    check("store.ctrl2", bus.CTRL_EX[2], 1);

    // Asynchronous reset mid-stream, with a flush parked
    bus.HOLD = 1'b1; bus.FLUSH = 1'b1;
    step("ar.park");
    RST_N = 1'b0;
    model_reset();
    #1;
    check_all("ar.async");
    @(negedge CLK);
    RST_N = 1'b1;
    set_idle();
    rand_data();
    step("ar.release");
    check("ar.no_squash", bus.VALID_EX, 1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rand_data();
      bus.ISA = 2'($urandom); bus.ISB = 2'($urandom); bus.ISD = 2'($urandom);
      bus.C_Unit_MUX = ($urandom_range(0, 3) != 0);
      bus.HOLD = ($urandom_range(0, 4) == 0);
      bus.FLUSH = ($urandom_range(0, 6) == 0);
      bus.CNT_CLR = ($urandom_range(0, 40) == 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
